// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported memory between an instruction
// fetch port and a load/store port. One transaction is in flight at a time.
// A data request wins a collision unless the fetch side has already lost
// STARVE_LIMIT grants in a row. A flush discards the fetch response in flight.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  // fetch port
  input  logic        instructionRequest,
  input  logic [31:0] instructionAddress,
  output logic [31:0] instructionData,
  output logic        instructionDataValid,
  // load/store port
  input  logic        dataRequest,
  input  logic        dataWrite,
  input  logic [31:0] dataAddress,
  input  logic [31:0] storeData,
  input  logic [3:0]  byteEnable,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete,
  // memory side
  output logic        memRequest,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memStoreData,
  output logic [3:0]  memByteEnable,
  input  logic        memReady,
  input  logic        memResponseValid,
  input  logic [31:0] memResponseData,
  // status
  output logic        busy
);

  localparam int COUNT_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [COUNT_WIDTH-1:0] STARVE_MAX = COUNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } stateType;

  typedef enum logic {
    OWNER_INSTRUCTION = 1'b0,
    OWNER_DATA        = 1'b1
  } ownerType;

  stateType               state;
  stateType               nextState;
  ownerType               owner;
  logic                   grantData;
  logic                   grantInstruction;
  logic                   requestWrite;
  logic [31:0]            requestAddress;
  logic [31:0]            requestStoreData;
  logic [3:0]             requestByteEnable;
  logic [COUNT_WIDTH-1:0] starveCount;
  logic                   discard;

  // The memory side only ever sees the latched copy of the granted request,
  // so requester-side changes cannot disturb a transaction in progress.
  assign memWrite      = requestWrite;
  assign memAddress    = requestAddress;
  assign memStoreData  = requestStoreData;
  assign memByteEnable = requestByteEnable;

  // State register: returns to IDLE immediately on reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of block evaluation order.
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state and grant selection; requests are only looked at in IDLE.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    nextState        = state;
    grantData        = 1'b0;
    grantInstruction = 1'b0;
    case (state)
      IDLE: begin
        if (dataRequest && !(instructionRequest && (starveCount == STARVE_MAX))) begin
          grantData = 1'b1;
        end else if (instructionRequest) begin
          grantInstruction = 1'b1;
        end
        if (grantData || grantInstruction) nextState = ISSUE;
      end
      ISSUE:   if (memReady)         nextState = WAIT;
      WAIT:    if (memResponseValid) nextState = RESPOND;
      RESPOND: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output decode: request strobe, busy flag and one-cycle response pulses.
  always_comb begin
    memRequest           = (state == ISSUE);
    busy                 = (state != IDLE);
    instructionDataValid = 1'b0;
    loadDataValid        = 1'b0;
    storeComplete        = 1'b0;
    if (state == RESPOND) begin
      if (owner == OWNER_INSTRUCTION) begin
        // A flush in this very cycle also kills the fetch response.
        instructionDataValid = !discard && !flush;
      end else if (requestWrite) begin
        storeComplete = 1'b1;
      end else begin
        loadDataValid = 1'b1;
      end
    end
  end

  // Request latch, starvation counter, discard flag and response capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner             <= OWNER_INSTRUCTION;
      requestWrite      <= 1'b0;
      requestAddress    <= '0;
      requestStoreData  <= '0;
      requestByteEnable <= '0;
      starveCount       <= '0;
      discard           <= 1'b0;
      loadData          <= '0;
      instructionData   <= '0;
    end else begin
      if (grantData) begin
        owner             <= OWNER_DATA;
        requestWrite      <= dataWrite;
        requestAddress    <= dataAddress;
        requestStoreData  <= storeData;
        requestByteEnable <= byteEnable;
      end else if (grantInstruction) begin
        owner             <= OWNER_INSTRUCTION;
        requestWrite      <= 1'b0;
        requestAddress    <= instructionAddress;
        requestStoreData  <= '0;
        requestByteEnable <= 4'hF;
      end

      // Counts data wins over a waiting fetch; any IDLE cycle without a
      // pending fetch, or a fetch grant, starts the count over.
      if (state == IDLE) begin
        if (grantInstruction || !instructionRequest) begin
          starveCount <= '0;
        end else if (grantData && (starveCount != STARVE_MAX)) begin
          starveCount <= starveCount + COUNT_WIDTH'(1);
        end
      end

      // The memory transaction itself cannot be cancelled, so a flush only
      // marks the fetch result as unwanted.
      if (state == IDLE) begin
        discard <= 1'b0;
      end else if (((state == ISSUE) || (state == WAIT)) && flush &&
                   (owner == OWNER_INSTRUCTION)) begin
        discard <= 1'b1;
      end

      // Capture on the edge into RESPOND so the data is valid with the pulse.
      if ((state == WAIT) && memResponseValid) begin
        if (owner == OWNER_INSTRUCTION) begin
          instructionData <= memResponseData;
        end else if (!requestWrite) begin
          loadData <= memResponseData;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter: reset, single fetch, collision,
// starvation, store, flush variants and reset in the middle of a transaction.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        instructionRequest;
  logic [31:0] instructionAddress;
  logic [31:0] instructionData;
  logic        instructionDataValid;
  logic        dataRequest;
  logic        dataWrite;
  logic [31:0] dataAddress;
  logic [31:0] storeData;
  logic [3:0]  byteEnable;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        memRequest;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memStoreData;
  logic [3:0]  memByteEnable;
  logic        memReady;
  logic        memResponseValid;
  logic [31:0] memResponseData;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  // pulse / strobe counters maintained by the monitor below
  int iPulses = 0;
  int lPulses = 0;
  int sPulses = 0;
  int reqHigh = 0;

  // memory-side fields captured in the first ISSUE cycle of a transaction
  logic [31:0] capAddr;
  logic [31:0] capStore;
  logic        capWrite;
  logic [3:0]  capBe;

  memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock               (clock),
    .reset               (reset),
    .flush               (flush),
    .instructionRequest  (instructionRequest),
    .instructionAddress  (instructionAddress),
    .instructionData     (instructionData),
    .instructionDataValid(instructionDataValid),
    .dataRequest         (dataRequest),
    .dataWrite           (dataWrite),
    .dataAddress         (dataAddress),
    .storeData           (storeData),
    .byteEnable          (byteEnable),
    .loadData            (loadData),
    .loadDataValid       (loadDataValid),
    .storeComplete       (storeComplete),
    .memRequest          (memRequest),
    .memWrite            (memWrite),
    .memAddress          (memAddress),
    .memStoreData        (memStoreData),
    .memByteEnable       (memByteEnable),
    .memReady            (memReady),
    .memResponseValid    (memResponseValid),
    .memResponseData     (memResponseData),
    .busy                (busy)
  );

  always #5 clock = ~clock;

  // Count every cycle each pulse/strobe is high, sampled mid-cycle.
  always @(negedge clock) begin
    #1;
    if (instructionDataValid === 1'b1) iPulses++;
    if (loadDataValid === 1'b1)        lPulses++;
    if (storeComplete === 1'b1)        sPulses++;
    if (memRequest === 1'b1)           reqHigh++;
  end

  // Memory model: waits for memRequest, withholds memReady for readyDelay
  // cycles, then responds respDelay cycles into WAIT. Returns at the
  // negedge of the RESPOND cycle. Optional one-cycle flush in ISSUE or WAIT.
  task automatic memServe(input int readyDelay, input int respDelay,
                          input logic [31:0] resp, input bit flushIssue,
                          input bit flushWait, output int reqCycles,
                          output int latency);
    bit found;
    found     = 1'b0;
    reqCycles = 0;
    latency   = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      latency++;
      if (memRequest === 1'b1) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL memRequestTimeout: memRequest stayed low for 20 cycles, required 1");
      return;
    end
    capAddr   = memAddress;
    capStore  = memStoreData;
    capWrite  = memWrite;
    capBe     = memByteEnable;
    reqCycles = 1;
    if (flushIssue) flush = 1'b1;
    for (int i = 0; i < readyDelay; i++) begin
      @(negedge clock);
      latency++;
      flush = 1'b0;
      compared++;
      if (memRequest !== 1'b1 || memAddress !== capAddr || memStoreData !== capStore ||
          memWrite !== capWrite || memByteEnable !== capBe) begin
        mismatched++;
        $display("FAIL memHold: memRequest=%b addr=%h while not ready, required 1 addr=%h",
                 memRequest, memAddress, capAddr);
      end
      if (memRequest === 1'b1) reqCycles++;
    end
    memReady = 1'b1;
    @(negedge clock);
    latency++;
    memReady = 1'b0;
    flush    = 1'b0;
    compared++;
    if (memRequest !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL waitState: memRequest=%b busy=%b after accept, required 0 1",
               memRequest, busy);
    end
    if (flushWait) flush = 1'b1;
    for (int i = 0; i < respDelay; i++) begin
      @(negedge clock);
      latency++;
      flush = 1'b0;
    end
    memResponseValid = 1'b1;
    memResponseData  = resp;
    @(negedge clock);
    latency++;
    flush            = 1'b0;
    memResponseValid = 1'b0;
    memResponseData  = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    compared++;
    if (busy !== 1'b0 || memRequest !== 1'b0) begin
      mismatched++;
      $display("FAIL resetState: busy=%b memRequest=%b, required 0 0", busy, memRequest);
    end
    compared++;
    if (memWrite !== 1'b0 || memAddress !== 32'h0 || memStoreData !== 32'h0 ||
        memByteEnable !== 4'h0) begin
      mismatched++;
      $display("FAIL resetMemFields: write=%b addr=%h store=%h be=%h, required all 0",
               memWrite, memAddress, memStoreData, memByteEnable);
    end
    compared++;
    if (loadData !== 32'h0 || instructionData !== 32'h0 || instructionDataValid !== 1'b0 ||
        loadDataValid !== 1'b0 || storeComplete !== 1'b0) begin
      mismatched++;
      $display("FAIL resetResponses: load=%h instr=%h iv=%b lv=%b sc=%b, required all 0",
               loadData, instructionData, instructionDataValid, loadDataValid, storeComplete);
    end
    reset = 1'b0;
    @(negedge clock);
    #1;
    compared++;
    if (memRequest !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL postReset: memRequest=%b busy=%b with no request, required 0 0",
               memRequest, busy);
    end
  endtask

  task automatic test_single_fetch();
    int rc, lat, i0, r0;
    i0 = iPulses;
    r0 = reqHigh;
    instructionAddress = 32'h0000_0010;
    instructionRequest = 1'b1;
    memServe(0, 0, 32'h0050_0093, 1'b0, 1'b0, rc, lat);
    #1;
    compared++;
    if (instructionDataValid !== 1'b1 || instructionData !== 32'h0050_0093) begin
      mismatched++;
      $display("FAIL fetchResponse: valid=%b data=%h, required 1 00500093",
               instructionDataValid, instructionData);
    end
    compared++;
    if (lat != 3) begin
      mismatched++;
      $display("FAIL fetchLatency: %0d cycles, required 3", lat);
    end
    compared++;
    if (capAddr !== 32'h0000_0010 || capWrite !== 1'b0) begin
      mismatched++;
      $display("FAIL fetchMemFields: addr=%h write=%b, required 00000010 0", capAddr, capWrite);
    end
    instructionRequest = 1'b0;
    @(negedge clock);
    #1;
    compared++;
    if (instructionDataValid !== 1'b0 || instructionData !== 32'h0050_0093 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL fetchAfter: valid=%b data=%h busy=%b, required 0 00500093 0",
               instructionDataValid, instructionData, busy);
    end
    compared++;
    if (iPulses - i0 != 1 || reqHigh - r0 != 1) begin
      mismatched++;
      $display("FAIL fetchPulseCounts: validCycles=%0d memRequestCycles=%0d, required 1 1",
               iPulses - i0, reqHigh - r0);
    end
  endtask

  task automatic test_collision();
    int rc, lat;
    dataAddress        = 32'h0000_0200;
    dataWrite          = 1'b0;
    dataRequest        = 1'b1;
    instructionAddress = 32'h0000_0100;
    instructionRequest = 1'b1;
    memServe(0, 0, 32'h1111_2222, 1'b0, 1'b0, rc, lat);
    #1;
    compared++;
    if (capAddr !== 32'h0000_0200 || capWrite !== 1'b0) begin
      mismatched++;
      $display("FAIL collisionFirstGrant: addr=%h write=%b, required 00000200 0", capAddr, capWrite);
    end
    compared++;
    if (loadDataValid !== 1'b1 || loadData !== 32'h1111_2222 || instructionDataValid !== 1'b0) begin
      mismatched++;
      $display("FAIL collisionLoad: lv=%b load=%h iv=%b, required 1 11112222 0",
               loadDataValid, loadData, instructionDataValid);
    end
    dataRequest = 1'b0;
    memServe(0, 0, 32'h3333_4444, 1'b0, 1'b0, rc, lat);
    #1;
    compared++;
    if (capAddr !== 32'h0000_0100 || instructionDataValid !== 1'b1 ||
        instructionData !== 32'h3333_4444) begin
      mismatched++;
      $display("FAIL collisionSecondGrant: addr=%h iv=%b data=%h, required 00000100 1 33334444",
               capAddr, instructionDataValid, instructionData);
    end
    compared++;
    if (lat != 4) begin
      mismatched++;
      $display("FAIL backToBack: %0d cycles between responses, required 4", lat);
    end
    instructionRequest = 1'b0;
    @(negedge clock);
    #1;
  endtask

  task automatic test_starvation();
    int rc, lat;
    logic [31:0] expectAddr;
    dataAddress        = 32'h0000_0400;
    dataWrite          = 1'b0;
    dataRequest        = 1'b1;
    instructionAddress = 32'h0000_0080;
    instructionRequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      memServe(0, 0, 32'h0000_1000 + 32'(k), 1'b0, 1'b0, rc, lat);
      #1;
      expectAddr = (k < 4) ? 32'h0000_0400 : 32'h0000_0080;
      compared++;
      if (capAddr !== expectAddr) begin
        mismatched++;
        $display("FAIL starveGrant%0d: addr=%h, required %h", k, capAddr, expectAddr);
      end
      compared++;
      if (int'(dut.starveCount) != ((k < 4) ? k + 1 : 0)) begin
        mismatched++;
        $display("FAIL starveCount%0d: %0d, required %0d", k, dut.starveCount,
                 (k < 4) ? k + 1 : 0);
      end
      compared++;
      if (lat != ((k == 0) ? 3 : 4)) begin
        mismatched++;
        $display("FAIL starveLatency%0d: %0d, required %0d", k, lat, (k == 0) ? 3 : 4);
      end
      if (k == 4) begin
        instructionRequest = 1'b0;
        dataRequest        = 1'b0;
      end
    end
    @(negedge clock);
    #1;
    compared++;
    if (int'(dut.starveCount) != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL starveEnd: count=%0d busy=%b, required 0 0", dut.starveCount, busy);
    end
  endtask

  task automatic test_store();
    int rc, lat, l0, s0;
    logic [31:0] loadBefore;
    loadBefore  = loadData;
    l0          = lPulses;
    s0          = sPulses;
    dataAddress = 32'h0000_0300;
    dataWrite   = 1'b1;
    storeData   = 32'hDEAD_BEEF;
    byteEnable  = 4'b0011;
    dataRequest = 1'b1;
    memServe(0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, rc, lat);
    #1;
    compared++;
    if (capAddr !== 32'h0000_0300 || capWrite !== 1'b1 || capStore !== 32'hDEAD_BEEF ||
        capBe !== 4'b0011) begin
      mismatched++;
      $display("FAIL storeMemFields: addr=%h write=%b store=%h be=%b, required 00000300 1 deadbeef 0011",
               capAddr, capWrite, capStore, capBe);
    end
    compared++;
    if (storeComplete !== 1'b1 || loadDataValid !== 1'b0 || loadData !== loadBefore) begin
      mismatched++;
      $display("FAIL storeResponse: sc=%b lv=%b load=%h, required 1 0 %h",
               storeComplete, loadDataValid, loadData, loadBefore);
    end
    dataRequest = 1'b0;
    dataWrite   = 1'b0;
    @(negedge clock);
    #1;
    compared++;
    if (sPulses - s0 != 1 || lPulses - l0 != 0) begin
      mismatched++;
      $display("FAIL storePulseCounts: storeComplete=%0d loadDataValid=%0d, required 1 0",
               sPulses - s0, lPulses - l0);
    end
  endtask

  task automatic test_flush();
    int rc, lat, i0;
    // flush during a stalled ISSUE
    i0 = iPulses;
    instructionAddress = 32'h0000_0040;
    instructionRequest = 1'b1;
    memServe(3, 0, 32'hAAAA_5555, 1'b1, 1'b0, rc, lat);
    #1;
    compared++;
    if (rc != 4 || instructionDataValid !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL flushIssue: memRequestCycles=%0d iv=%b busy=%b, required 4 0 1",
               rc, instructionDataValid, busy);
    end
    instructionRequest = 1'b0;
    @(negedge clock);
    // flush during WAIT, memReady delayed 3 cycles
    instructionRequest = 1'b1;
    memServe(3, 1, 32'h5555_AAAA, 1'b0, 1'b1, rc, lat);
    #1;
    compared++;
    if (rc != 4 || instructionDataValid !== 1'b0) begin
      mismatched++;
      $display("FAIL flushWait: memRequestCycles=%0d iv=%b, required 4 0", rc, instructionDataValid);
    end
    instructionRequest = 1'b0;
    @(negedge clock);
    // flush coinciding with RESPOND
    instructionRequest = 1'b1;
    memServe(0, 0, 32'h1234_5678, 1'b0, 1'b0, rc, lat);
    flush = 1'b1;
    #1;
    compared++;
    if (instructionDataValid !== 1'b0) begin
      mismatched++;
      $display("FAIL flushRespond: iv=%b, required 0", instructionDataValid);
    end
    flush              = 1'b0;
    instructionRequest = 1'b0;
    @(negedge clock);
    #1;
    compared++;
    if (iPulses - i0 != 0) begin
      mismatched++;
      $display("FAIL flushPulseCount: %0d valid cycles, required 0", iPulses - i0);
    end
    // the next fetch is delivered normally
    instructionRequest = 1'b1;
    memServe(0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, rc, lat);
    #1;
    compared++;
    if (instructionDataValid !== 1'b1 || instructionData !== 32'h0BAD_F00D) begin
      mismatched++;
      $display("FAIL flushRecover: iv=%b data=%h, required 1 0badf00d",
               instructionDataValid, instructionData);
    end
    instructionRequest = 1'b0;
    @(negedge clock);
    // flush has no effect on a load
    dataAddress = 32'h0000_0500;
    dataWrite   = 1'b0;
    dataRequest = 1'b1;
    memServe(0, 0, 32'hC0FF_EE00, 1'b0, 1'b1, rc, lat);
    #1;
    compared++;
    if (loadDataValid !== 1'b1 || loadData !== 32'hC0FF_EE00) begin
      mismatched++;
      $display("FAIL flushData: lv=%b load=%h, required 1 c0ffee00", loadDataValid, loadData);
    end
    dataRequest = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_wait();
    int rc, lat;
    instructionAddress = 32'h0000_0060;
    instructionRequest = 1'b1;
    @(negedge clock);              // ISSUE
    memReady = 1'b1;
    @(negedge clock);              // WAIT
    memReady = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b1 || memRequest !== 1'b0) begin
      mismatched++;
      $display("FAIL midWaitSetup: busy=%b memRequest=%b, required 1 0", busy, memRequest);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (busy !== 1'b0 || memRequest !== 1'b0 || memAddress !== 32'h0 || instructionData !== 32'h0) begin
      mismatched++;
      $display("FAIL asyncReset: busy=%b memRequest=%b addr=%h instr=%h, required 0 0 0 0",
               busy, memRequest, memAddress, instructionData);
    end
    instructionRequest = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    instructionRequest = 1'b1;
    memServe(0, 0, 32'h0000_0013, 1'b0, 1'b0, rc, lat);
    #1;
    compared++;
    if (instructionDataValid !== 1'b1 || instructionData !== 32'h0000_0013 ||
        capAddr !== 32'h0000_0060 || lat != 3) begin
      mismatched++;
      $display("FAIL fetchAfterReset: iv=%b data=%h addr=%h latency=%0d, required 1 00000013 00000060 3",
               instructionDataValid, instructionData, capAddr, lat);
    end
    instructionRequest = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset              = 1'b1;
    flush              = 1'b0;
    instructionRequest = 1'b0;
    instructionAddress = 32'h0;
    dataRequest        = 1'b0;
    dataWrite          = 1'b0;
    dataAddress        = 32'h0;
    storeData          = 32'h0;
    byteEnable         = 4'h0;
    memReady           = 1'b0;
    memResponseValid   = 1'b0;
    memResponseData    = 32'h0;
    test_reset();
    test_single_fetch();
    test_collision();
    test_starvation();
    test_store();
    test_flush();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time limit in case a wait escapes its own bound.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
